console_out: RTL and testbench

Memory-mapped output console peripheral on the single-cycle MIPS machine's data bus, beside the timer. It is the responder for the CPU's load/store traffic. Stores to its data port enqueue bytes into a small FIFO, which drains to an external sink over a valid/ready handshake. It raises a sticky interrupt to cp0 when the FIFO drains empty.

---
 rtl/console_out.sv | 162 ++++++++++++++++
 tb/tb_console_out.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/console_out.sv
// ---------------------------------------------------------------------------
// console_out
//   Memory-mapped output console for the single-cycle MIPS data bus.
//   CPU stores to DATA push bytes into a small circular FIFO that drains to
//   an external sink over a valid/ready handshake. A sticky interrupt is
//   raised when the FIFO drains empty while interrupts are enabled.
//
//   Register map (exact word addresses):
//     0xffff0010 DATA   : store enqueues data[7:0]; load returns 0
//     0xffff0014 STATUS : {20'b0, ie, ovf, full, empty, 3'b0, count[4:0]}
//     0xffff0018 CTRL   : store bit0 -> ie, bit1 clears ovf, bit2 clears
//                         pending; load returns {31'b0, ie}
//
// Ports:
//   clk              machine clock, all state on rising edge
//   reset            asynchronous active-high reset
//   address          CPU data address
//   data             CPU store data
//   MemRead          CPU load strobe
//   MemWrite         CPU store strobe
//   rd_data          read data to writeback mux, 0 when not selected
//   ConsoleAddress   address hits one of the three registers
//   ConsoleInterrupt interrupt request to cp0 (sticky pending flag)
//   tx_byte          head-of-FIFO byte
//   tx_valid         FIFO non-empty
//   tx_ready         sink accepts tx_byte this cycle
// ---------------------------------------------------------------------------
module console_out #(
    parameter int DEPTH = 8,
    parameter int CW    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd_data,
    output logic        ConsoleAddress,
    output logic        ConsoleInterrupt,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [31:0] ADDR_DATA   = 32'hffff_0010;
    localparam logic [31:0] ADDR_STATUS = 32'hffff_0014;
    localparam logic [31:0] ADDR_CTRL   = 32'hffff_0018;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    // FIFO storage and control state
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_ie;
    logic          r_ovf;
    logic          r_pending;

    // Decode and handshake
    logic          w_sel_data;
    logic          w_sel_status;
    logic          w_sel_ctrl;
    logic          w_empty;
    logic          w_full;
    logic          w_data_wr;
    logic          w_ctrl_wr;
    logic          w_enq;
    logic          w_deq;
    logic          w_set_pend;
    logic [4:0]    w_count5;
    logic          w_unused_data;

    assign w_sel_data     = (address == ADDR_DATA);
    assign w_sel_status   = (address == ADDR_STATUS);
    assign w_sel_ctrl     = (address == ADDR_CTRL);
    assign ConsoleAddress = w_sel_data | w_sel_status | w_sel_ctrl;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_data_wr = MemWrite & w_sel_data;
    assign w_ctrl_wr = MemWrite & w_sel_ctrl;

    // Both decisions use the pre-edge count, so a store against a full FIFO
    // is dropped even when the sink frees a slot in the same cycle.
    assign w_enq = w_data_wr & ~w_full;
    assign w_deq = ~w_empty & tx_ready;

    // Emptying dequeue: last byte leaves and nothing replaces it.
    assign w_set_pend = w_deq & ~w_enq & (r_count == ONE_CNT) & r_ie;

    assign tx_valid         = ~w_empty;
    assign tx_byte          = r_mem[r_head];
    assign ConsoleInterrupt = r_pending;

    assign w_count5      = 5'(r_count);
    assign w_unused_data = ^data[31:8];

    always_comb begin
        rd_data = 32'h0;
        if (MemRead) begin
            if (w_sel_status) begin
                rd_data = {20'b0, r_ie, r_ovf, w_full, w_empty, 3'b0, w_count5};
            end else if (w_sel_ctrl) begin
                rd_data = {31'b0, r_ie};
            end
        end
    end

    // Byte storage carries no reset; only valid entries are ever observed.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ie      <= 1'b0;
            r_ovf     <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end

            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end

            if (w_ctrl_wr) begin
                r_ie <= data[0];
            end

            if (w_data_wr && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_ctrl_wr && data[1]) begin
                r_ovf <= 1'b0;
            end

            // A coincident set beats the software acknowledge.
            if (w_set_pend) begin
                r_pending <= 1'b1;
            end else if (w_ctrl_wr && data[2]) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_console_out.sv
module tb_console_out;

    localparam logic [31:0] A_DATA   = 32'hffff_0010;
    localparam logic [31:0] A_STATUS = 32'hffff_0014;
    localparam logic [31:0] A_CTRL   = 32'hffff_0018;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd_data;
    logic        ConsoleAddress;
    logic        ConsoleInterrupt;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks;
    int n_fail;

    console_out #(.DEPTH(8), .CW(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .address          (address),
        .data             (data),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .rd_data          (rd_data),
        .ConsoleAddress   (ConsoleAddress),
        .ConsoleInterrupt (ConsoleInterrupt),
        .tx_byte          (tx_byte),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store spanning exactly one rising edge; starts and ends near a falling edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        address  = a;
        data     = d;
        MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        address  = 32'h0;
    endtask

    // Combinational load; no clock edge passes.
    task automatic load(input logic [31:0] a, output logic [31:0] rd, output logic hit);
        address = a;
        MemRead = 1'b1;
        #1;
        rd  = rd_data;
        hit = ConsoleAddress;
        MemRead = 1'b0;
        address = 32'h0;
        #1;
    endtask

    logic [31:0] rd;
    logic        hit;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        address  = 32'h0;
        data     = 32'h0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_irq", {31'b0, ConsoleInterrupt}, 32'd0);
        load(A_STATUS, rd, hit);
        chk("rst_status", rd, 32'h0000_0100);
        chk("status_hit", {31'b0, hit}, 32'd1);

        // Three bytes, no same-cycle bypass
        address = A_DATA; data = 32'h41; MemWrite = 1'b1;
        #1;
        chk("no_bypass", {31'b0, tx_valid}, 32'd0);
        @(negedge clk);
        MemWrite = 1'b0;
        chk("enq_latency", {31'b0, tx_valid}, 32'd1);
        store(A_DATA, 32'h42);
        store(A_DATA, 32'hdead_be43);
        load(A_STATUS, rd, hit);
        chk("status_cnt3", rd, 32'h0000_0003);
        load(A_DATA, rd, hit);
        chk("data_load_zero", rd, 32'h0);
        chk("head_41", {24'b0, tx_byte}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain3_valid", {31'b0, tx_valid}, 32'd1);
            chk("drain3_byte", {24'b0, tx_byte}, 32'h41 + i);
            @(negedge clk);
        end
        chk("drain3_empty", {31'b0, tx_valid}, 32'd0);
        chk("drain3_noirq", {31'b0, ConsoleInterrupt}, 32'd0);
        tx_ready = 1'b0;

        // Overflow: nine stores into eight slots
        for (int i = 0; i < 9; i++) store(A_DATA, i);
        load(A_STATUS, rd, hit);
        chk("status_full_ovf", rd, 32'h0000_0608);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_byte", {24'b0, tx_byte}, i);
            @(negedge clk);
        end
        chk("ovf_drain_empty", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        load(A_STATUS, rd, hit);
        chk("status_ovf_sticky", rd, 32'h0000_0500);
        store(A_CTRL, 32'h2);
        load(A_STATUS, rd, hit);
        chk("status_ovf_clr", rd, 32'h0000_0100);

        // Full with same-cycle dequeue: store still dropped
        for (int i = 0; i < 8; i++) store(A_DATA, 32'h10 + i);
        tx_ready = 1'b1;
        store(A_DATA, 32'h99);
        load(A_STATUS, rd, hit);
        chk("full_deq_drop", rd, 32'h0000_0407);
        for (int i = 0; i < 7; i++) begin
            chk("full_deq_byte", {24'b0, tx_byte}, 32'h11 + i);
            @(negedge clk);
        end
        chk("full_deq_empty", {31'b0, tx_valid}, 32'd0);
        store(A_CTRL, 32'h2);
        chk("ie0_noirq", {31'b0, ConsoleInterrupt}, 32'd0);
        tx_ready = 1'b0;

        // Interrupt on empty
        store(A_CTRL, 32'h1);
        load(A_CTRL, rd, hit);
        chk("ctrl_ie1", rd, 32'h1);
        store(A_DATA, 32'h55);
        chk("irq_pre", {31'b0, ConsoleInterrupt}, 32'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("irq_set", {31'b0, ConsoleInterrupt}, 32'd1);
        chk("irq_empty", {31'b0, tx_valid}, 32'd0);
        store(A_CTRL, 32'h5);
        chk("irq_ack", {31'b0, ConsoleInterrupt}, 32'd0);
        load(A_STATUS, rd, hit);
        chk("status_ie_kept", rd, 32'h0000_0900);

        // Ack coinciding with emptying dequeue: set wins
        store(A_DATA, 32'h66);
        tx_ready = 1'b1;
        store(A_CTRL, 32'h5);
        tx_ready = 1'b0;
        chk("irq_set_wins", {31'b0, ConsoleInterrupt}, 32'd1);
        store(A_CTRL, 32'h0);
        chk("ie0_keeps_pend", {31'b0, ConsoleInterrupt}, 32'd1);
        load(A_CTRL, rd, hit);
        chk("ctrl_ie0", rd, 32'h0);
        store(A_CTRL, 32'h4);
        chk("irq_ack2", {31'b0, ConsoleInterrupt}, 32'd0);

        // Decode
        load(32'h1001_0000, rd, hit);
        chk("miss_hit", {31'b0, hit}, 32'd0);
        chk("miss_rd", rd, 32'h0);
        address = A_STATUS;
        #1;
        chk("noread_rd", rd_data, 32'h0);
        chk("noread_hit", {31'b0, ConsoleAddress}, 32'd1);
        address = 32'h0;

        // Asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) store(A_DATA, 32'h70 + i);
        chk("pre_rst_valid", {31'b0, tx_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, tx_valid}, 32'd0);
        load(A_STATUS, rd, hit);
        chk("async_rst_status", rd, 32'h0000_0100);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, tx_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
